imem_miss_ctrl: RTL and testbench
=================================

# imem_miss_ctrl

Main-memory fetch controller sitting directly upstream of the instruction cache. On a cache miss it latches the word address from `PC`, waits a fixed, parameterised memory latency, then returns the instruction word on `Data_MM` with a one-cycle `Access_MM` strobe, which the cache uses to fill a line. It owns the word-addressed backing store, which has a write port for program loading, and a response counter for statistics.

## Interface
- `ADDR_WIDTH`, 10, word-address bits; backing store holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 4, clock edges from request capture to the `Access_MM` assertion; legal range 1..15.
- `CLK` in 1: single clock; all state changes on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `PC` in 32: fetch address; word index is `PC[ADDR_WIDTH+1:2]`.
- `Miss` in 1: miss request from the cache, active-high (the inverse of the cache's HitWrite).
- `Init_WE` in 1: backing-store write enable for program loading.
- `Init_Addr` in ADDR_WIDTH: write word index.
- `Init_Data` in 32: write data.
- `Access_MM` out 1: one-cycle strobe; `Data_MM` is valid while it is high.
- `Data_MM` out 32: fetched instruction word.
- `Busy` out 1: high in every state except IDLE.
- `CNT_ACCESS` out 20: number of completed responses.

## Operation
- Three-state FSM: IDLE, WAIT, RESP. State, `Access_MM`, `Data_MM` and `CNT_ACCESS` are registered.
- **IDLE.** On an edge with `Miss`=1:
  - latch `addr_q <= PC[ADDR_WIDTH+1:2]`;
  - load `cnt <= LATENCY-1`;
  - go to WAIT.
  - With `Miss`=0, stay in IDLE.
- **WAIT.** On each edge:
  - if `cnt != 0`: `cnt <= cnt-1`;
  - if `cnt == 0`: `Data_MM <= mem[addr_q]`, `Access_MM <= 1`, `CNT_ACCESS <= CNT_ACCESS+1`, go to RESP.
- **RESP.** On the next edge: `Access_MM <= 0`, go to IDLE.
  - `Miss` is ignored on this edge, so back-to-back requests are spaced by at least one IDLE cycle.
  - `Data_MM` holds its value until the next response.
- `Miss`, `PC` changes and `Miss` deassertion during WAIT or RESP are ignored. The latched `addr_q` is used and the request always completes.
- Address wrap: `PC` bits above ADDR_WIDTH+1 are ignored, so `mem` aliases modulo 2^ADDR_WIDTH. `PC[1:0]` is ignored.
- **Init writes.**
  - A write with `Init_WE`=1 commits at the edge, in any state.
  - If the write and the response read hit the same index on the same edge, the response returns the old data (read-before-write).
  - A write on an earlier edge is visible to the response.
- **Counter.** `CNT_ACCESS` wraps from 2^20-1 to 0.
- **Reset.**
  - `RESET` high forces IDLE, `Access_MM`=0, `Data_MM`=0, `CNT_ACCESS`=0, `cnt`=0, `addr_q`=0, and `Busy` therefore 0. All of these take effect immediately, without waiting for a clock edge.
  - Backing-store contents are not cleared.
  - Reset in WAIT or RESP aborts the request with no strobe; the first post-reset request restarts the full latency.

## Timing
- The request is captured at edge T. `Access_MM` rises after edge T+LATENCY and falls after edge T+LATENCY+1.
- The earliest next capture is edge T+LATENCY+2, which gives a throughput of one word per LATENCY+2 cycles.
- `Busy` rises after edge T and falls after edge T+LATENCY+1.
- `Access_MM` and `Data_MM` are stable for the whole high cycle of the strobe, so the cache samples them at edge T+LATENCY+1.

## Test plan
- Reset, preload `mem[5]`=0xDEADBEEF, hold `Miss`=1 with `PC`=0x14 for one edge -> with LATENCY=4, `Access_MM` high exactly one cycle after edge T+4, `Data_MM`=0xDEADBEEF, `CNT_ACCESS`=1, `Busy` high T+1..T+5.
- Capture `PC`=0x14, then change `PC` to 0x20 and toggle `Miss` during WAIT -> response still returns `mem[5]`, and no second request is accepted until after RESP.
- `PC`=0x00001014 with ADDR_WIDTH=10 -> aliases to index 5 and returns 0xDEADBEEF.
- Write `mem[5]`=0x12345678 on the same edge as the response -> `Data_MM`=0xDEADBEEF. A subsequent miss to 0x14 -> 0x12345678.
- Assert `RESET` two cycles into WAIT -> `Access_MM` never pulses, all outputs are 0 immediately, memory is retained. The next miss completes after LATENCY edges.
- `Miss` held high continuously for 3 requests with LATENCY=1 -> strobes spaced 3 cycles apart, `CNT_ACCESS`=3.

Source files
------------

// File: rtl/imem_miss_ctrl_if.sv
// imem_miss_ctrl_if
//   Bundles the cache-side request/response signals and the program-load
//   write port of the main-memory fetch controller.
//   master : cache / loader side (drives PC, Miss, Init_*)
//   slave  : imem_miss_ctrl (drives Access_MM, Data_MM, Busy, CNT_ACCESS)
interface imem_miss_ctrl_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [31:0]           PC;
  logic                  Miss;
  logic                  Init_WE;
  logic [ADDR_WIDTH-1:0] Init_Addr;
  logic [31:0]           Init_Data;
  logic                  Access_MM;
  logic [31:0]           Data_MM;
  logic                  Busy;
  logic [19:0]           CNT_ACCESS;

  modport master (
    output PC, Miss, Init_WE, Init_Addr, Init_Data,
    input  Access_MM, Data_MM, Busy, CNT_ACCESS
  );

  modport slave (
    input  PC, Miss, Init_WE, Init_Addr, Init_Data,
    output Access_MM, Data_MM, Busy, CNT_ACCESS
  );
endinterface

// File: rtl/imem_miss_ctrl.sv
// imem_miss_ctrl
//   Main-memory fetch controller upstream of the instruction cache. A miss
//   latches the word address, waits LATENCY edges, then returns the word from
//   the backing store with a one-cycle Access_MM strobe.
//   Ports:
//     CLK   : single clock, rising edge
//     RESET : asynchronous, active-high
//     bus   : imem_miss_ctrl_if.slave
//             in  PC, Miss, Init_WE, Init_Addr, Init_Data
//             out Access_MM, Data_MM, Busy, CNT_ACCESS
//
//   state  | meaning
//   S_IDLE | waiting for Miss; captures PC and loads the latency counter
//   S_WAIT | counting down the memory latency; reads and strobes at zero
//   S_RESP | strobe cycle; Miss ignored, returns to S_IDLE
module imem_miss_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  imem_miss_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_access;
  logic [31:0]           r_data;
  logic [19:0]           r_cnt_access;
  logic [31:0]           r_mem [2**ADDR_WIDTH];

  wire [ADDR_WIDTH-1:0] w_pc_idx = bus.PC[ADDR_WIDTH+1:2];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_addr       <= '0;
      r_access     <= 1'b0;
      r_data       <= 32'd0;
      r_cnt_access <= 20'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Miss) begin
            r_addr  <= w_pc_idx;
            r_cnt   <= LAT_M1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Non-blocking read of r_mem gives read-before-write against
            // an Init write landing on the same edge.
            r_data       <= r_mem[r_addr];
            r_access     <= 1'b1;
            r_cnt_access <= r_cnt_access + 20'd1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_access <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_access <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Backing store is deliberately outside the reset domain so program
  // contents survive RESET.
  always_ff @(posedge CLK) begin
    if (bus.Init_WE) begin
      r_mem[bus.Init_Addr] <= bus.Init_Data;
    end
  end

  assign bus.Access_MM  = r_access;
  assign bus.Data_MM    = r_data;
  assign bus.Busy       = (r_state != S_IDLE);
  assign bus.CNT_ACCESS = r_cnt_access;

endmodule

// File: tb/tb_imem_miss_ctrl.sv
module tb_imem_miss_ctrl;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]   pc    = 32'd0;
  logic          miss  = 1'b0;
  logic          we    = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [31:0]   wdata = 32'd0;

  imem_miss_ctrl_if #(.ADDR_WIDTH(AW)) ifc4 ();
  imem_miss_ctrl_if #(.ADDR_WIDTH(AW)) ifc1 ();

  assign ifc4.PC = pc;  assign ifc4.Miss = miss;  assign ifc4.Init_WE = we;
  assign ifc4.Init_Addr = waddr;  assign ifc4.Init_Data = wdata;
  assign ifc1.PC = pc;  assign ifc1.Miss = miss;  assign ifc1.Init_WE = we;
  assign ifc1.Init_Addr = waddr;  assign ifc1.Init_Data = wdata;

  imem_miss_ctrl #(.ADDR_WIDTH(AW), .LATENCY(4)) dut4 (.CLK(clk), .RESET(rst), .bus(ifc4));
  imem_miss_ctrl #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (.CLK(clk), .RESET(rst), .bus(ifc1));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request captured at edge c is answered at edge
  // c+lat; the following edge is the strobe cycle, then the controller is free.
  int            lat    [2] = '{4, 1};
  bit            m_pend [2];
  int            m_cap  [2];
  logic [AW-1:0] m_addr [2];
  bit            m_acc  [2];
  logic [31:0]   m_data [2];
  logic [19:0]   m_cnt  [2];
  logic [31:0]   m_mem  [2**AW];
  int            edge_n = 0;

  logic        d_acc  [2];
  logic        d_busy [2];
  logic [31:0] d_data [2];
  logic [19:0] d_cnt  [2];
  assign d_acc[0] = ifc4.Access_MM;  assign d_busy[0] = ifc4.Busy;
  assign d_data[0] = ifc4.Data_MM;   assign d_cnt[0] = ifc4.CNT_ACCESS;
  assign d_acc[1] = ifc1.Access_MM;  assign d_busy[1] = ifc1.Busy;
  assign d_data[1] = ifc1.Data_MM;   assign d_cnt[1] = ifc1.CNT_ACCESS;

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_pend[k] = 1'b0; m_acc[k] = 1'b0; m_data[k] = 32'd0; m_cnt[k] = 20'd0;
        end else if (m_acc[k]) begin
          m_acc[k] = 1'b0;
        end else if (m_pend[k]) begin
          if (edge_n == m_cap[k] + lat[k]) begin
            m_data[k] = m_mem[m_addr[k]];
            m_acc[k]  = 1'b1;
            m_cnt[k]  = m_cnt[k] + 20'd1;
            m_pend[k] = 1'b0;
          end
        end else if (miss) begin
          m_pend[k] = 1'b1;
          m_cap[k]  = edge_n;
          m_addr[k] = pc[AW+1:2];
        end
      end
      if (we) m_mem[waddr] = wdata;
      edge_n++;
      #1;
      for (int k = 0; k < 2; k++) begin
        chk(k == 0 ? "m4_access" : "m1_access", 32'(d_acc[k]), 32'(m_acc[k]));
        chk(k == 0 ? "m4_busy" : "m1_busy", 32'(d_busy[k]), 32'(m_pend[k] | m_acc[k]));
        chk(k == 0 ? "m4_cnt" : "m1_cnt", 32'(d_cnt[k]), 32'(m_cnt[k]));
        chk(k == 0 ? "m4_data" : "m1_data", d_data[k], m_data[k]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Issue a one-edge miss on the LATENCY=4 unit and wait (bounded) for the strobe.
  task automatic request4(input logic [31:0] a, output logic [31:0] data, output int lat_seen);
    bit found = 1'b0;
    tick();
    pc = a; miss = 1'b1;
    tick();
    miss = 1'b0;
    lat_seen = 0;
    data = 32'd0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ifc4.Access_MM) begin
        found = 1'b1; data = ifc4.Data_MM;
      end else begin
        tick(); lat_seen++;
      end
    end
    if (!found) begin
      fails++; tests++;
      $display("FAIL req4_timeout: got no strobe expected strobe for pc 0x%0h", a);
    end
    tick();
  endtask

  logic [31:0] rd;
  int          lt;
  int          spos [3];
  int          scnt;

  initial begin
    tick(); tick();
    chk("rst_access", 32'(ifc4.Access_MM), 32'd0);
    chk("rst_busy",   32'(ifc4.Busy), 32'd0);
    chk("rst_data",   ifc4.Data_MM, 32'd0);
    chk("rst_cnt",    32'(ifc4.CNT_ACCESS), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 2**AW; i++) begin
      we = 1'b1; waddr = AW'(i);
      wdata = (i == 5) ? 32'hDEADBEEF : $urandom;
      tick();
    end
    we = 1'b0;
    tick();

    // Basic latency/strobe timing on the LATENCY=4 unit
    pc = 32'h14; miss = 1'b1;
    tick();
    miss = 1'b0;
    chk("t1_busy_T", 32'(ifc4.Busy), 32'd1);
    chk("t1_acc_T", 32'(ifc4.Access_MM), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_acc_wait", 32'(ifc4.Access_MM), 32'd0);
      chk("t1_busy_wait", 32'(ifc4.Busy), 32'd1);
    end
    tick();
    chk("t1_acc_T4", 32'(ifc4.Access_MM), 32'd1);
    chk("t1_data", ifc4.Data_MM, 32'hDEADBEEF);
    chk("t1_cnt", 32'(ifc4.CNT_ACCESS), 32'd1);
    chk("t1_busy_T4", 32'(ifc4.Busy), 32'd1);
    tick();
    chk("t1_acc_T5", 32'(ifc4.Access_MM), 32'd0);
    chk("t1_busy_T5", 32'(ifc4.Busy), 32'd0);
    tick();

    // PC/Miss changes during WAIT are ignored; Miss ignored in RESP
    pc = 32'h14; miss = 1'b1;
    tick();
    pc = 32'h20; miss = 1'b0;
    tick(); miss = 1'b1;
    tick(); miss = 1'b0;
    scnt = 0;
    for (int i = 0; i < 6 && !ifc4.Access_MM; i++) begin
      tick(); scnt++;
    end
    chk("t2_acc", 32'(ifc4.Access_MM), 32'd1);
    chk("t2_data", ifc4.Data_MM, 32'hDEADBEEF);
    miss = 1'b1;
    tick();
    chk("t2_resp_ignore", 32'(ifc4.Busy), 32'd0);
    miss = 1'b0;
    tick();

    // Address aliasing
    request4(32'h0000_1014, rd, lt);
    chk("t3_alias", rd, 32'hDEADBEEF);

    // Same-edge write returns old data, later read sees new data
    tick();
    pc = 32'h14; miss = 1'b1;
    tick(); miss = 1'b0;
    tick(); tick(); tick();
    we = 1'b1; waddr = AW'(5); wdata = 32'h12345678;
    tick(); we = 1'b0;
    chk("t4_acc", 32'(ifc4.Access_MM), 32'd1);
    chk("t4_rbw", ifc4.Data_MM, 32'hDEADBEEF);
    tick();
    request4(32'h14, rd, lt);
    chk("t4_new", rd, 32'h12345678);

    // Reset two cycles into WAIT
    tick();
    pc = 32'h14; miss = 1'b1;
    tick(); miss = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("t5_acc", 32'(ifc4.Access_MM), 32'd0);
    chk("t5_busy", 32'(ifc4.Busy), 32'd0);
    chk("t5_data", ifc4.Data_MM, 32'd0);
    chk("t5_cnt", 32'(ifc4.CNT_ACCESS), 32'd0);
    chk("t5_busy1", 32'(ifc1.Busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_strobe", 32'(ifc4.Access_MM), 32'd0);
    end
    rst = 1'b0;
    request4(32'h14, rd, lt);
    chk("t5_retained", rd, 32'h12345678);
    chk("t5_latency", 32'(lt), 32'd4);
    chk("t5_cnt_after", 32'(ifc4.CNT_ACCESS), 32'd1);

    // LATENCY=1 unit with Miss held high: strobes every 3 cycles
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    pc = 32'h14; miss = 1'b1;
    scnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifc1.Access_MM) begin
        if (scnt < 3) spos[scnt] = i;
        scnt++;
      end
      if (i == 6) miss = 1'b0;
    end
    chk("t6_strobes", 32'(scnt), 32'd3);
    chk("t6_first", 32'(spos[0]), 32'd1);
    chk("t6_gap1", 32'(spos[1] - spos[0]), 32'd3);
    chk("t6_gap2", 32'(spos[2] - spos[1]), 32'd3);
    chk("t6_cnt", 32'(ifc1.CNT_ACCESS), 32'd3);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 249) == 0);
      miss  = ($urandom_range(0, 2) == 0);
      pc    = $urandom;
      if ($urandom_range(0, 3) == 0) pc[AW+1:2] = AW'($urandom_range(0, 7));
      we    = !rst && ($urandom_range(0, 3) == 0);
      waddr = AW'($urandom_range(0, 7));
      wdata = $urandom;
      tick();
    end
    rst = 1'b0; miss = 1'b0; we = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
